serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through a registered carry chain. It is the sequential successor to our single-bit combinational adder cells. It gives a small-area adder with a start/done handshake for datapaths where latency is acceptable and wide ripple logic is not.

## Interface

Parameters:
- WIDTH, default 8: operand and sum width in bits; must be ≥ 1.
- DIGIT, default 1: bits added per cycle; WIDTH must be a multiple of DIGIT. DIGIT = WIDTH is legal (single-cycle RUN).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  WIDTH  operand A, captured on the accepting edge.
- y  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle.
- sum  output  WIDTH  result register; holds its value until the next completion.
- cout  output  1  final carry-out; holds its value like sum.

## Operation

- Let K = WIDTH/DIGIT. The state machine has two states, IDLE and RUN.
- IDLE, start = 1 on an edge:
  - latch x, y and cin into the shift registers and carry register;
  - clear the digit counter;
  - go to RUN.
- IDLE, start = 0: hold state. sum, cout and the operand registers are unchanged.
- RUN, each edge:
  - add the low DIGIT bits of the A and B shift registers and the carry register;
  - shift the DIGIT result bits into the top of the partial-sum register, which fills LSB-first;
  - shift the operands right by DIGIT;
  - store the new carry;
  - increment the counter.
- RUN, on the K-th edge:
  - copy the completed partial sum to sum and the carry to cout;
  - set done for the following cycle;
  - return to IDLE.
- start while busy is ignored. It is not queued.
- Arithmetic: {cout, sum} = x + y + cin, modulo 2^(WIDTH+1). It is unsigned, with no overflow flag.
- Reset (asynchronous, any state, including mid-RUN):
  - state goes to IDLE; counter, carry and shift registers go to 0;
  - sum = 0, cout = 0, busy = 0, done = 0;
  - the in-flight operation is discarded and produces no done.

## Timing

- Reset values: busy 0, done 0, sum 0, cout 0.
- With start accepted at edge E0: busy is high from after E0 through the edge E0+K; done is high for exactly one cycle, after edge E0+K. Latency is K cycles from the accepting edge.
- done and busy are never high together.
- sum and cout update only at the completing edge and are stable while busy.
- start held high in the done cycle is accepted, because the block is in IDLE. This gives back-to-back throughput of one result per K+1 cycles.
- start held continuously gives a result every K+1 cycles.
- x, y and cin may change freely after the accepting edge.
- busy and done are registered outputs with no combinational path from inputs.

## Structure

- Package serial_adder_pkg holds:
  - the state encoding constants (IDLE = 0, RUN = 1);
  - the counter-width function clog2, with counter width = clog2(K), minimum 1.
- One sub-module, digit_adder: a combinational DIGIT-bit ripple adder (a, b, ci → s, co) built from per-bit full-adder cells.
- The top level holds the FSM, counter, shift registers, carry register and output registers.
- Target size: about 150–250 lines of RTL.

## Test plan

- WIDTH=8, DIGIT=1; x=8'hFF, y=8'h01, cin=0, start one cycle → busy 8 cycles, then done pulse; sum=8'h00, cout=1.
- WIDTH=8, DIGIT=4; x=8'h3C, y=8'h5A, cin=1 → done 2 cycles after accept; sum=8'h97, cout=0. In the same setup, start pulsed during busy is ignored: exactly one done, with the result unchanged.
- WIDTH=16, DIGIT=2; start held high continuously with operands changing after each accept (16'hFFFF+16'hFFFF+1, then 16'h1234+16'h0001+0) → dones 9 cycles apart; results {1,16'hFFFF}, then {0,16'h1235}.
- Reset mid-RUN: WIDTH=8, DIGIT=1, rst asserted asynchronously 3 cycles after accept → busy, done, sum and cout all 0 immediately; no done follows. The next start completes correctly.
- DIGIT=WIDTH=8; x=8'h80, y=8'h80, cin=0 → done 1 cycle after accept; sum=8'h00, cout=1.
- Randomised self-check, 1000 operations per configuration (8/1, 8/4, 16/2, 32/8): compare {cout, sum} against x+y+cin and check the done spacing.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder shared definitions.
// State encoding and counter sizing helpers.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Digit counter width; never narrower than one bit.
  function automatic int cnt_width(input int k);
    return (clog2(k) < 1) ? 1 : clog2(k);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple adder.
// One full-adder cell per bit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  // Full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder, DIGIT bits per clock.
// Start/done handshake, registered carry chain.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = cnt_width(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] ps_q;
  logic             c_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic [DIGIT-1:0] ds;
  logic             dco;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] ps_d;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a (a_q[DIGIT-1:0]),
    .b (b_q[DIGIT-1:0]),
    .ci(c_q),
    .s (ds),
    .co(dco)
  );

  // Next operand digits and LSB-first partial sum fill.
  assign a_d  = a_q >> DIGIT;
  assign b_d  = b_q >> DIGIT;
  assign ps_d = WIDTH'({ds, ps_q} >> DIGIT);

  // FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= x;
            b_q     <= y;
            c_q     <= cin;
            ps_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          c_q   <= dco;
          ps_q  <= ps_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= ps_d;
            cout_q  <= dco;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder.
// Five configurations run side by side.
module tb_serial_adder;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nfin = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int g, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s got %h expected %h",
               g, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : gen_dut
    localparam int W = (g == 2) ? 16 : (g == 3) ? 32 : 8;
    localparam int D = (g == 0) ? 1 : (g == 1) ? 4 :
                       (g == 2) ? 2 : 8;
    localparam int K = W / D;
    localparam int R = (K > 3) ? 3 : K - 1;

    logic         rst_l = 1'b1;
    logic         start_l = 1'b0;
    logic         cin_l = 1'b0;
    logic [W-1:0] x_l = '0;
    logic [W-1:0] y_l = '0;
    logic         busy_l;
    logic         done_l;
    logic         cout_l;
    logic [W-1:0] sum_l;

    logic [W:0]   qv[$];
    int           qd[$];
    logic [W:0]   last = '0;

    serial_adder #(
      .WIDTH(W),
      .DIGIT(D)
    ) u_dut (
      .clk  (clk),
      .rst  (rst_l),
      .start(start_l),
      .x    (x_l),
      .y    (y_l),
      .cin  (cin_l),
      .busy (busy_l),
      .done (done_l),
      .sum  (sum_l),
      .cout (cout_l)
    );

    // Start one op at a negedge; mode picks start during busy:
    // 0 low, 1 random, 2 held high.
    task automatic issue(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic c, input int mode);
      logic [W:0] ev;
      ev = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      start_l = 1'b1;
      x_l = a;
      y_l = b;
      cin_l = c;
      qv.push_back(ev);
      qd.push_back(cyc + 1 + K);
      @(negedge clk);
      for (int j = 0; j < K; j++) begin
        start_l = (mode == 2) ? 1'b1 :
                  (mode == 1) ? 1'($urandom) : 1'b0;
        x_l = W'($urandom);
        y_l = W'($urandom);
        cin_l = 1'($urandom);
        @(negedge clk);
      end
    endtask

    function automatic logic [W-1:0] rnd_op();
      if ($urandom % 8 == 0) return '1;
      if ($urandom % 8 == 0) return '0;
      return W'($urandom);
    endfunction

    // Stimulus: directed ops, reset mid-run, random ops.
    initial begin
      repeat (3) @(posedge clk);
      #1 rst_l = 1'b0;
      @(negedge clk);
      case (g)
        0: issue(W'(8'hFF), W'(8'h01), 1'b0, 0);
        1: issue(W'(8'h3C), W'(8'h5A), 1'b1, 2);
        2: begin
          issue(W'(16'hFFFF), W'(16'hFFFF), 1'b1, 2);
          issue(W'(16'h1234), W'(16'h0001), 1'b0, 2);
        end
        3: issue('1, W'(1), 1'b0, 0);
        default: issue(W'(8'h80), W'(8'h80), 1'b0, 0);
      endcase
      start_l = 1'b0;
      @(negedge clk);
      start_l = 1'b1;
      x_l = W'($urandom);
      y_l = W'($urandom);
      cin_l = 1'b1;
      qv.push_back({1'b0, x_l} + {1'b0, y_l} + 1);
      qd.push_back(cyc + 1 + K);
      @(posedge clk);
      #1 start_l = 1'b0;
      repeat (R) @(posedge clk);
      #2 rst_l = 1'b1;
      qv.delete();
      qd.delete();
      #1;
      chk(g, "async_rst_busy", 64'(busy_l), 64'd0);
      chk(g, "async_rst_done", 64'(done_l), 64'd0);
      chk(g, "async_rst_sum", 64'(sum_l), 64'd0);
      chk(g, "async_rst_cout", 64'(cout_l), 64'd0);
      @(posedge clk);
      #1 rst_l = 1'b0;
      @(negedge clk);
      issue(W'(8'h21), W'(8'h42), 1'b1, 1);
      start_l = 1'b0;
      @(negedge clk);
      repeat (1000) begin
        issue(rnd_op(), rnd_op(), 1'($urandom),
              int'($urandom % 3));
        if ($urandom % 3 == 0) begin
          start_l = 1'b0;
          repeat ($urandom % 3 + 1) @(negedge clk);
        end
      end
      start_l = 1'b0;
      repeat (3) @(negedge clk);
      nfin++;
    end

    // Monitor: compare outputs to the scoreboard each negedge.
    initial begin
      logic eb;
      forever begin
        @(negedge clk);
        if (rst_l) begin
          last = '0;
          chk(g, "rst_outputs",
              64'({busy_l, done_l, cout_l, sum_l}), 64'd0);
        end else begin
          eb = (qd.size() > 0) && (cyc >= qd[0] - K) &&
               (cyc < qd[0]);
          chk(g, "busy", 64'(busy_l), 64'(eb));
          if (done_l) begin
            if (qv.size() == 0) begin
              chk(g, "done_unexpected", 64'(done_l), 64'd0);
            end else begin
              chk(g, "done_cycle", 64'(cyc), 64'(qd[0]));
              last = qv.pop_front();
              void'(qd.pop_front());
            end
          end else if (qd.size() > 0 && cyc >= qd[0]) begin
            chk(g, "done_missing", 64'(done_l), 64'd1);
            void'(qv.pop_front());
            void'(qd.pop_front());
          end
          chk(g, "cout_sum", 64'({cout_l, sum_l}), 64'(last));
          chk(g, "busy_done_excl", 64'(busy_l & done_l), 64'd0);
        end
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (nfin < 5 && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (nfin < 5) begin
      checks++;
      errors++;
      $display("FAIL timeout finished %0d expected 5", nfin);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
